// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer
//
// Adds two multi-word operands by streaming them one 16-bit limb per cycle,
// least significant limb first, through a single 16-bit adder. The carry out
// of each limb is kept in a register and fed into the next limb, so operands
// of 16*LIMBS bits are summed in LIMBS accepted cycles. Results come out one
// limb at a time through a single output register.
//
// Build option: define WIDE_ADD_SUBTRACT_EN to add the in_sub port. When
// in_sub is 1 on limb 0 the whole operand computes A - B. In that mode
// out_cout=1 means "no borrow".
//
// Handshake: a beat transfers on a rising edge where valid & ready are both 1.
// The producer holds its data stable while valid=1 and ready=0. Here
// in_ready = !out_valid | out_ready, so a new limb is taken whenever the
// output register is empty or is being drained in the same cycle. There is
// no combinational path from in_valid to out_valid.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready      input limb handshake
//   in_a, in_b             16-bit operand limbs
//   in_cin                 carry-in, used on limb 0 only
//   in_sub                 subtract select, limb 0 only (WIDE_ADD_SUBTRACT_EN)
//   out_valid/out_ready    output limb handshake
//   out_sum                16-bit sum limb
//   out_last               out_sum is the most significant limb
//   out_cout, out_ovf      final carry / signed overflow, 0 unless out_last
//   busy                   an operand is partially consumed
module wide_add_sequencer #(
  parameter int LIMBS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_cin,
`ifdef WIDE_ADD_SUBTRACT_EN
  input  logic        in_sub,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        out_last,
  output logic        out_cout,
  output logic        out_ovf,
  output logic        busy
);

  // The counter stays at least one bit wide even when LIMBS=1.
  localparam int IDX_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LIMBS - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             c_q, c_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      out_sum_q, out_sum_d;
  logic             out_last_q, out_last_d;
  logic             out_cout_q, out_cout_d;
  logic             out_ovf_q, out_ovf_d;
`ifdef WIDE_ADD_SUBTRACT_EN
  logic             sub_q, sub_d;
`endif

  logic        in_accept;
  logic        out_accept;
  logic        first_limb;
  logic        last_limb;
  logic        sub_eff;
  logic [15:0] b_eff;
  logic        carry_in;
  logic [16:0] add_res;

  assign in_ready = !out_valid_q | out_ready;

  always_comb begin
    in_accept  = in_valid & in_ready;
    out_accept = out_valid_q & out_ready;
    first_limb = (idx_q == '0);
    last_limb  = (idx_q == LAST_IDX);

`ifdef WIDE_ADD_SUBTRACT_EN
    // The subtract mode is taken from the port on limb 0 and then held for
    // the remaining limbs of the operand.
    sub_eff = first_limb ? in_sub : sub_q;
`else
    sub_eff = 1'b0;
`endif

    // Subtraction is A + ~B + 1; the +1 is injected as the limb-0 carry.
    b_eff    = sub_eff ? ~in_b : in_b;
    carry_in = first_limb ? (sub_eff | in_cin) : c_q;
    add_res  = {1'b0, in_a} + {1'b0, b_eff} + {16'd0, carry_in};

    idx_d       = idx_q;
    c_d         = c_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_last_d  = out_last_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;
`ifdef WIDE_ADD_SUBTRACT_EN
    sub_d       = sub_q;
`endif

    if (in_accept) begin
      idx_d       = last_limb ? '0 : idx_q + 1'b1;
      c_d         = add_res[16];
      out_valid_d = 1'b1;
      out_sum_d   = add_res[15:0];
      out_last_d  = last_limb;
      out_cout_d  = last_limb & add_res[16];
      // Signed overflow of the full-width result only depends on the top limb.
      out_ovf_d   = last_limb & (in_a[15] == b_eff[15]) & (add_res[15] != in_a[15]);
`ifdef WIDE_ADD_SUBTRACT_EN
      sub_d       = sub_eff;
`endif
    end else if (out_accept) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q       <= '0;
      c_q         <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= 16'd0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
`ifdef WIDE_ADD_SUBTRACT_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      idx_q       <= idx_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
`ifdef WIDE_ADD_SUBTRACT_EN
      sub_q       <= sub_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = (idx_q != '0);

endmodule
